sentinel_key_injector: RTL and testbench
========================================

SENTINEL_KEY_INJECTOR -- requirements
Module: sentinel_key_injector

Interface
REQ-001 Parameter PRESENT_DELAY, default 6: clocks from ena_out rise to first key_out drive; legal 5..7.
REQ-002 Parameter VERIFY_TIMEOUT, default 8: clocks to wait for the grant glyph after the key is driven; legal 1..255.
REQ-003 Parameter BACKOFF_CYCLES, default 32: idle clocks between attempts; legal 1..255.
REQ-004 Parameter MAX_RETRIES, default 3: total attempts before failure; legal 1..7.
REQ-005 clk  in  1  system clock, rising edge; one clock domain only.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to begin an unlock sequence.
REQ-008 abort  in  1  cancels any sequence.
REQ-009 hold  in  1  keeps authorization held while high once granted.
REQ-010 key_in  in  8  key value to present; sampled on an accepted start.
REQ-011 seg_in  in  8  lock 7-segment readback; 0xC1 = unlocked, 0xC7 = locked.
REQ-012 ena_out  out  8→1  enable to the lock (1 bit).
REQ-013 key_out  out  8  key bus to the lock; 0x00 when not presenting.
REQ-014 busy, granted, failed  out  1 each  status flags.
REQ-015 attempts  out  3  count of attempts started in the current sequence.

Function
REQ-016 All outputs SHALL be registered; the FSM SHALL have states IDLE, ARM, PRESENT, GRANTED, BACKOFF, FAILED.
REQ-017 IDLE or FAILED + start (no abort) SHALL latch key_in, clear failed, set attempts=1, busy=1, ena_out=1, and enter ARM at the same edge (edge E0).
REQ-018 start in ARM, PRESENT, GRANTED or BACKOFF SHALL be ignored.
REQ-019 ARM SHALL hold key_out=0x00 and enter PRESENT so that key_out equals the latched key from edge E0+PRESENT_DELAY.
REQ-020 PRESENT SHALL hold ena_out=1 and key_out=key, and count clocks; the count of 1 SHALL correspond to the first clock with key_out driven.
REQ-021 PRESENT SHALL enter GRANTED with granted=1 at the first edge at which seg_in==0xC1 is sampled.
REQ-022 PRESENT SHALL reach timeout when VERIFY_TIMEOUT clocks pass with no 0xC1 sampled.
REQ-023 On timeout with attempts<MAX_RETRIES, the block SHALL enter BACKOFF.
REQ-024 On timeout with attempts==MAX_RETRIES, the block SHALL enter FAILED.
REQ-025 BACKOFF SHALL drive ena_out=0 and key_out=0x00 for exactly BACKOFF_CYCLES clocks.
REQ-026 At the end of BACKOFF, the block SHALL increment attempts, re-assert ena_out, and enter ARM (new E0).
REQ-027 GRANTED SHALL hold ena_out=1 and key_out=key while hold=1.
REQ-028 In GRANTED, hold=0 SHALL return the block to IDLE, clearing ena_out, key_out, busy and granted.
REQ-029 In GRANTED, seg_in!=0xC1 for 2 consecutive samples SHALL enter FAILED; a single-cycle mismatch SHALL be tolerated.
REQ-030 FAILED SHALL drive failed=1, busy=0, granted=0, ena_out=0, key_out=0x00.
REQ-031 failed SHALL stay 1 until the next accepted start or reset; attempts SHALL hold its last value in FAILED.
REQ-032 abort SHALL force IDLE at the next edge from any state, with ena_out=0, key_out=0x00, busy=0 and granted=0.
REQ-033 abort SHALL leave failed and attempts unchanged.
REQ-034 abort SHALL take priority over start and over every other transition in the same cycle.
REQ-035 The internal counter SHALL be 8 bits and SHALL clear on every state entry.
REQ-036 attempts SHALL never exceed MAX_RETRIES.
REQ-037 An unreachable state encoding SHALL recover to IDLE with reset output values.

Reset
REQ-038 rst_n low SHALL immediately force: state IDLE, ena_out=0, key_out=0x00, busy=0, granted=0, failed=0, attempts=0, counter=0, latched key=0x00.
REQ-039 Reset SHALL take effect mid-sequence in any state with no residual retry.
REQ-040 Normal operation SHALL resume at the first clk edge after rst_n deasserts.

Verification
REQ-041 start, key_in=0xB6, defaults; seg_in=0xC1 from 2 clocks after the key is driven -> ena_out rises at E0, key_out=0xB6 at E0+6, granted=1 one edge after 0xC1 is sampled, attempts=1.
REQ-042 seg_in fixed 0xC7 -> per attempt: 8 PRESENT clocks then 32 clocks with ena_out=0; after the third timeout failed=1, attempts=3, busy=0, ena_out=0.
REQ-043 abort during PRESENT together with start -> next edge ena_out=0, key_out=0x00, busy=0, failed=0; start ignored.
REQ-044 GRANTED with hold=1: seg_in=0xC7 for 1 clock -> granted stays 1; seg_in=0xC7 for 2 clocks -> FAILED, failed=1.
REQ-045 rst_n pulsed low in BACKOFF with attempts=2 -> all outputs at reset values; no retry after release.
REQ-046 GRANTED, hold dropped -> next edge IDLE, ena_out=0, key_out=0x00, granted=0; a new start is accepted.

Source files
------------

// File: rtl/sentinel_key_injector.sv
// -----------------------------------------------------------------------------
// sentinel_key_injector
//
// Presents a key to an external lock and watches the lock's 7-segment readback
// for the "unlocked" glyph. Each attempt enables the lock, waits PRESENT_DELAY
// clocks before driving the key, then allows VERIFY_TIMEOUT clocks for the
// grant glyph. Failed attempts back off for BACKOFF_CYCLES idle clocks and
// retry, up to MAX_RETRIES attempts in total. Once granted, authorization is
// held while `hold` is high and the readback keeps showing the unlocked glyph.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle request to begin an unlock sequence
//   abort     in   cancel any sequence (highest priority)
//   hold      in   keep authorization held once granted
//   key_in    in   [7:0] key to present, sampled on an accepted start
//   seg_in    in   [7:0] lock readback: 0xC1 unlocked, 0xC7 locked
//   ena_out   out  enable to the lock
//   key_out   out  [7:0] key bus to the lock, 0x00 when not presenting
//   busy      out  a sequence is in progress
//   granted   out  lock reported unlocked and authorization is held
//   failed    out  sequence ended without (or lost) authorization
//   attempts  out  [2:0] attempts started in the current sequence
// -----------------------------------------------------------------------------
module sentinel_key_injector #(
    parameter int PRESENT_DELAY  = 6,
    parameter int VERIFY_TIMEOUT = 8,
    parameter int BACKOFF_CYCLES = 32,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    input  logic [7:0] key_in,
    input  logic [7:0] seg_in,
    output logic       ena_out,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       granted,
    output logic       failed,
    output logic [2:0] attempts
);

    localparam logic [7:0] SEG_UNLOCKED = 8'hC1;

    // Terminal counter values; the counter restarts at 0 on every state entry.
    localparam logic [7:0] ARM_LAST     = 8'(PRESENT_DELAY - 1);
    localparam logic [7:0] VERIFY_LAST  = 8'(VERIFY_TIMEOUT);
    localparam logic [7:0] BACKOFF_LAST = 8'(BACKOFF_CYCLES - 1);
    localparam logic [2:0] MAX_ATT      = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PRESENT = 3'd2,
        GRANTED = 3'd3,
        BACKOFF = 3'd4,
        FAILED  = 3'd5
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_key;
    logic       r_miss;   // one unlocked-glyph mismatch already seen in GRANTED

    // In PRESENT the clock index counts from 1 on the first clock the key is
    // on the bus, so the timeout fires on the VERIFY_TIMEOUT-th sample.
    logic [7:0] w_present_idx;
    assign w_present_idx = r_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_key    <= 8'h00;
            r_miss   <= 1'b0;
            ena_out  <= 1'b0;
            key_out  <= 8'h00;
            busy     <= 1'b0;
            granted  <= 1'b0;
            failed   <= 1'b0;
            attempts <= 3'd0;
        end else if (abort) begin
            // failed and attempts deliberately keep their values
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_miss  <= 1'b0;
            ena_out <= 1'b0;
            key_out <= 8'h00;
            busy    <= 1'b0;
            granted <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FAILED: begin
                    if (start) begin
                        r_state  <= ARM;
                        r_cnt    <= 8'd0;
                        r_key    <= key_in;
                        failed   <= 1'b0;
                        attempts <= 3'd1;
                        busy     <= 1'b1;
                        ena_out  <= 1'b1;
                        key_out  <= 8'h00;
                        granted  <= 1'b0;
                    end
                end

                ARM: begin
                    if (r_cnt == ARM_LAST) begin
                        r_state <= PRESENT;
                        r_cnt   <= 8'd0;
                        key_out <= r_key;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                PRESENT: begin
                    // A grant seen on the last sample wins over the timeout.
                    if (seg_in == SEG_UNLOCKED) begin
                        r_state <= GRANTED;
                        r_cnt   <= 8'd0;
                        r_miss  <= 1'b0;
                        granted <= 1'b1;
                    end else if (w_present_idx == VERIFY_LAST) begin
                        r_cnt   <= 8'd0;
                        ena_out <= 1'b0;
                        key_out <= 8'h00;
                        if (attempts >= MAX_ATT) begin
                            r_state <= FAILED;
                            failed  <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= BACKOFF;
                        end
                    end else begin
                        r_cnt <= w_present_idx;
                    end
                end

                BACKOFF: begin
                    if (r_cnt == BACKOFF_LAST) begin
                        r_state  <= ARM;
                        r_cnt    <= 8'd0;
                        attempts <= attempts + 3'd1;
                        ena_out  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                GRANTED: begin
                    if (!hold) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                        r_miss  <= 1'b0;
                        ena_out <= 1'b0;
                        key_out <= 8'h00;
                        busy    <= 1'b0;
                        granted <= 1'b0;
                    end else if (seg_in != SEG_UNLOCKED) begin
                        // Tolerate one glitched readback; two in a row lose the lock.
                        if (r_miss) begin
                            r_state <= FAILED;
                            r_cnt   <= 8'd0;
                            r_miss  <= 1'b0;
                            ena_out <= 1'b0;
                            key_out <= 8'h00;
                            busy    <= 1'b0;
                            granted <= 1'b0;
                            failed  <= 1'b1;
                        end else begin
                            r_miss <= 1'b1;
                        end
                    end else begin
                        r_miss <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= 8'd0;
                    r_key    <= 8'h00;
                    r_miss   <= 1'b0;
                    ena_out  <= 1'b0;
                    key_out  <= 8'h00;
                    busy     <= 1'b0;
                    granted  <= 1'b0;
                    failed   <= 1'b0;
                    attempts <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sentinel_key_injector.sv
module tb_sentinel_key_injector;

    localparam int PD = 6;
    localparam int VT = 8;
    localparam int BC = 32;
    localparam int MR = 3;
    localparam logic [7:0] C1 = 8'hC1;
    localparam logic [7:0] C7 = 8'hC7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic [7:0] seg_in = C7;
    logic       ena_out;
    logic [7:0] key_out;
    logic       busy;
    logic       granted;
    logic       failed;
    logic [2:0] attempts;

    sentinel_key_injector #(
        .PRESENT_DELAY(PD), .VERIFY_TIMEOUT(VT),
        .BACKOFF_CYCLES(BC), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .key_in(key_in), .seg_in(seg_in), .ena_out(ena_out), .key_out(key_out),
        .busy(busy), .granted(granted), .failed(failed), .attempts(attempts)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Packed observation: {ena, key[7:0], busy, granted, failed, attempts[2:0]}
    typedef logic [14:0] obs_t;
    obs_t exp_q[$];

    function automatic obs_t pack(input logic e, input logic [7:0] k, input logic b,
                                  input logic g, input logic f, input logic [2:0] a);
        return {e, k, b, g, f, a};
    endfunction

    // ---------------- reference model (time since attempt start) -------------
    // phase: 0 idle, 1 attempt in progress, 2 granted, 3 failed
    int         m_phase = 0;
    int         m_t     = 0;     // clocks since the current attempt's enable edge
    int         m_att   = 0;
    bit         m_failed = 0;
    logic [7:0] m_key   = 8'h00;
    int         m_miss  = 0;

    function automatic void model_reset();
        m_phase = 0; m_t = 0; m_att = 0; m_failed = 0; m_key = 8'h00; m_miss = 0;
    endfunction

    function automatic void model_step(input bit st, input bit ab, input bit hd,
                                       input logic [7:0] k, input logic [7:0] s);
        if (ab) begin
            m_phase = 0;
            return;
        end
        case (m_phase)
            0, 3: if (st) begin
                m_phase = 1; m_t = 0; m_att = 1; m_failed = 0; m_key = k;
            end
            1: begin
                m_t++;
                if (m_t > PD && m_t <= PD + VT) begin
                    // this edge samples the readback while the key is on the bus
                    if (s == C1) begin
                        m_phase = 2; m_miss = 0;
                    end else if (m_t == PD + VT && m_att == MR) begin
                        m_phase = 3; m_failed = 1;
                    end
                end else if (m_t == PD + VT + BC) begin
                    m_att++; m_t = 0;
                end
            end
            2: begin
                if (!hd) m_phase = 0;
                else if (s != C1) begin
                    m_miss++;
                    if (m_miss == 2) begin m_phase = 3; m_failed = 1; end
                end else m_miss = 0;
            end
            default: ;
        endcase
    endfunction

    function automatic obs_t model_out();
        logic [2:0] a;
        a = 3'(m_att);
        case (m_phase)
            1: begin
                if (m_t < PD)           return pack(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, a);
                else if (m_t < PD + VT) return pack(1'b1, m_key, 1'b1, 1'b0, 1'b0, a);
                else                    return pack(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
            end
            2:       return pack(1'b1, m_key, 1'b1, 1'b1, 1'b0, a);
            3:       return pack(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
            default: return pack(1'b0, 8'h00, 1'b0, 1'b0, m_failed, a);
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        obs_t act, exp_v;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act   = {ena_out, key_out, busy, granted, failed, attempts};
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d actual={ena,key,busy,gr,fail,att}=%h required=%h",
                         cyc, act, exp_v);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input bit st, input bit ab, input bit hd,
                        input logic [7:0] k, input logic [7:0] s);
        @(negedge clk);
        rst_n = 1'b1; start = st; abort = ab; hold = hd; key_in = k; seg_in = s;
        model_step(st, ab, hd, k, s);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_ticks(input int n, input logic [7:0] s);
        for (int i = 0; i < n; i++) tick(0, 0, 1, 8'($urandom), s);
    endtask

    // Assert reset at a falling edge; outputs must clear without waiting for clk.
    task automatic reset_pulse(input int n);
        obs_t act;
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        act = {ena_out, key_out, busy, granted, failed, attempts};
        n_tests++;
        if (act !== 15'h0) begin
            n_fail++;
            $display("FAIL async_reset actual=%h required=%h", act, 15'h0);
        end
        model_reset();
        exp_q.push_back(model_out());
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            exp_q.push_back(model_out());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_pulse(3);

        // Grant: 0xC1 appears two clocks after the key is on the bus.
        tick(1, 0, 1, 8'hB6, C7);
        idle_ticks(PD + 1, C7);
        idle_ticks(4, C1);
        // Single glitch tolerated, then a double glitch loses the grant.
        idle_ticks(1, C7);
        idle_ticks(3, C1);
        idle_ticks(2, C7);
        idle_ticks(3, C1);

        // Start ignored while busy; lock never opens -> three attempts then fail.
        tick(1, 0, 1, 8'h5A, C7);
        tick(1, 0, 1, 8'hFF, C7);
        idle_ticks(3 * (PD + VT + BC), C7);
        idle_ticks(5, C7);

        // Grant then release hold; a new start is accepted right after.
        tick(1, 0, 1, 8'h3C, C7);
        idle_ticks(PD, C7);
        idle_ticks(3, C1);
        tick(0, 0, 0, 8'h00, C1);
        tick(1, 0, 1, 8'h77, C1);
        idle_ticks(PD + 3, C1);

        // Abort together with start while presenting.
        tick(0, 0, 0, 8'h00, C7);
        tick(1, 0, 1, 8'h99, C7);
        idle_ticks(PD + 2, C7);
        tick(1, 1, 1, 8'h11, C7);
        idle_ticks(4, C7);

        // Reset while backing off on the second attempt: no retry afterwards.
        tick(1, 0, 1, 8'hE4, C7);
        idle_ticks(PD + VT + BC + PD + VT + 5, C7);
        reset_pulse(2);
        idle_ticks(PD + VT + BC + 10, C1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [7:0] s;
            r = $urandom_range(0, 9);
            s = (r < 5) ? C1 : (r < 9) ? C7 : 8'($urandom);
            tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 31) != 0), 8'($urandom), s);
        end

        @(negedge clk);
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
